mash_dsm_nch: RTL and testbench

Parametrised multi-channel MASH delta-sigma requantiser. It is the successor to the fixed two-channel MASH 1-1 stage in the DSM datapath. It takes NUM_CH unsigned NCO samples per AXI-stream beat and emits NUM_CH signed DAC_BW-bit codes. The modulator order is selectable at run time: bypass, MASH-1, MASH 1-1 or MASH 1-1-1. It also provides shared LFSR dither, output saturation with a sticky flag, and full backpressure. It sits between the NCO bank and the mod2 / upconverter stages.

---
 rtl/mash_dsm_nch.sv | 172 +++++++++++++++++
 tb/tb_mash_dsm_nch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mash_dsm_nch.sv
// mash_dsm_nch: multi-channel MASH delta-sigma requantiser.
// Each channel splits an unsigned sample into integer and fractional parts.
// The fractional part drives a run-time selectable MASH cascade: bypass, 1, 1-1 or 1-1-1.
// The carry-derived correction is added to the mid-scale-centred integer part.
// The result is saturated to a signed DAC_BW-bit code.
// State advances only on an accepted AXI-stream beat.
module mash_dsm_nch #(
  parameter int          NUM_CH    = 2,
  parameter int          WIDTH     = 16,
  parameter int          FRAC_BW   = 12,
  parameter int          DAC_BW    = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       aclk,
  input  logic                       arst_n,
  input  logic [1:0]                 mode,
  input  logic                       dither_enable,
  input  logic [NUM_CH*WIDTH-1:0]    s_axis_data_tdata,
  input  logic                       s_axis_data_tvalid,
  output logic                       s_axis_data_tready,
  output logic [NUM_CH*DAC_BW-1:0]   m_axis_data_tdata,
  output logic                       m_axis_data_tvalid,
  input  logic                       m_axis_data_tready,
  output logic [NUM_CH-1:0]          sat_flag,
  input  logic                       sat_clear
);

  localparam int INT_BW  = WIDTH - FRAC_BW;
  localparam int OW      = INT_BW + 3;
  localparam int SAT_MAX = (1 << (DAC_BW - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DAC_BW - 1));
  localparam logic signed [OW-1:0] MID = OW'(1 << (INT_BW - 1));

  // Zero-extend a carry bit into the signed correction width.
  function automatic logic signed [OW-1:0] bit_ext(input logic b);
    return {{(OW-1){1'b0}}, b};
  endfunction

  logic        m_tvalid_reg;
  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;
  logic [1:0]  last_mode_reg;
  logic        accept;
  logic        restart;
  logic        dith_bit;

  // No bubble: a new beat may enter whenever the output slot is empty or draining.
  assign s_axis_data_tready = !m_tvalid_reg || m_axis_data_tready;
  assign accept             = s_axis_data_tvalid && s_axis_data_tready;
  // A mode change makes every stage start from zero on that beat.
  assign restart            = (mode != last_mode_reg);
  assign dith_bit           = dither_enable & lfsr_reg[0];
  // Right-shifting Fibonacci LFSR (x^16+x^14+x^13+x^11+1); bit 0 is the dither output.
  assign lfsr_next          = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
  assign m_axis_data_tvalid = m_tvalid_reg;

  // Shared control state: output valid, dither LFSR and the last accepted mode.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      m_tvalid_reg  <= 1'b0;
      lfsr_reg      <= LFSR_SEED;
      last_mode_reg <= 2'b00;
    end else begin
      if (accept) begin
        m_tvalid_reg  <= 1'b1;
        lfsr_reg      <= lfsr_next;
        last_mode_reg <= mode;
      end else if (m_axis_data_tready) begin
        m_tvalid_reg  <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [FRAC_BW-1:0]     e1_reg, e2_reg, e3_reg;
      logic [FRAC_BW-1:0]     e1_eff, e2_eff, e3_eff;
      logic [FRAC_BW-1:0]     e1_new, e2_new, e3_new;
      logic                   c2_z1_reg, c3_z1_reg, c3_z2_reg;
      logic                   c2_z1_eff, c3_z1_eff, c3_z2_eff;
      logic                   c1, c2, c3;
      logic [INT_BW-1:0]      x_int;
      logic [FRAC_BW-1:0]     x_frac;
      logic signed [OW-1:0]   n_val;
      logic signed [OW-1:0]   out_val;
      logic signed [31:0]     out_ext;
      logic [DAC_BW-1:0]      code_next;
      logic [DAC_BW-1:0]      code_reg;
      logic                   sat_now;
      logic                   sat_reg;

      assign x_int  = s_axis_data_tdata[gi*WIDTH+FRAC_BW +: INT_BW];
      assign x_frac = s_axis_data_tdata[gi*WIDTH +: FRAC_BW];

      // Cascade arithmetic, correction term and saturation for one channel.
      always_comb begin
        e1_eff    = restart ? '0 : e1_reg;
        e2_eff    = restart ? '0 : e2_reg;
        e3_eff    = restart ? '0 : e3_reg;
        c2_z1_eff = restart ? 1'b0 : c2_z1_reg;
        c3_z1_eff = restart ? 1'b0 : c3_z1_reg;
        c3_z2_eff = restart ? 1'b0 : c3_z2_reg;
        {c1, e1_new} = {1'b0, e1_eff} + {1'b0, x_frac} + {{FRAC_BW{1'b0}}, dith_bit};
        {c2, e2_new} = {1'b0, e2_eff} + {1'b0, e1_new};
        {c3, e3_new} = {1'b0, e3_eff} + {1'b0, e2_new};
        n_val = '0;
        case (mode)
          2'b01: n_val = bit_ext(c1);
          2'b10: n_val = bit_ext(c1) + bit_ext(c2) - bit_ext(c2_z1_eff);
          2'b11: n_val = bit_ext(c1) + bit_ext(c2) - bit_ext(c2_z1_eff)
                       + bit_ext(c3) - (bit_ext(c3_z1_eff) <<< 1) + bit_ext(c3_z2_eff);
          default: n_val = '0;
        endcase
        out_val   = signed'({3'b000, x_int}) - MID + n_val;
        out_ext   = 32'(out_val);
        sat_now   = 1'b0;
        code_next = out_ext[DAC_BW-1:0];
        if (out_ext > SAT_MAX) begin
          sat_now   = 1'b1;
          code_next = DAC_BW'(SAT_MAX);
        end else if (out_ext < SAT_MIN) begin
          sat_now   = 1'b1;
          code_next = DAC_BW'(SAT_MIN);
        end
      end

      // Modulator state; stages unused by the current mode are parked at zero.
      always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
          e1_reg    <= '0;
          e2_reg    <= '0;
          e3_reg    <= '0;
          c2_z1_reg <= 1'b0;
          c3_z1_reg <= 1'b0;
          c3_z2_reg <= 1'b0;
        end else if (accept) begin
          e1_reg    <= (mode == 2'b00) ? '0 : e1_new;
          e2_reg    <= mode[1] ? e2_new : '0;
          e3_reg    <= (&mode) ? e3_new : '0;
          c2_z1_reg <= mode[1] & c2;
          c3_z1_reg <= (&mode) & c3;
          c3_z2_reg <= (&mode) & c3_z1_eff;
        end
      end

      // Output code register; holds while the downstream stalls.
      always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
          code_reg <= '0;
        end else if (accept) begin
          code_reg <= code_next;
        end
      end

      // Sticky saturation flag; a saturating beat beats a simultaneous clear.
      always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
          sat_reg <= 1'b0;
        end else if (accept && sat_now) begin
          sat_reg <= 1'b1;
        end else if (sat_clear) begin
          sat_reg <= 1'b0;
        end
      end

      assign m_axis_data_tdata[gi*DAC_BW +: DAC_BW] = code_reg;
      assign sat_flag[gi]                           = sat_reg;
    end
  endgenerate

endmodule

// File: tb/tb_mash_dsm_nch.sv
// tb_mash_dsm_nch: directed-vector bench for mash_dsm_nch.
// Two instances (DAC_BW 5 and 4) share one stimulus stream so saturation can be observed.
module tb_mash_dsm_nch;

  logic        aclk = 1'b0;
  logic        arst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        dither_enable = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        m_tready = 1'b1;
  logic        sat_clear = 1'b0;

  logic        s_tready5, s_tready4;
  logic        m_tvalid5, m_tvalid4;
  logic [9:0]  m_tdata5;
  logic [7:0]  m_tdata4;
  logic [1:0]  sat5, sat4;

  int checks = 0;
  int errors = 0;

  int t2_exp [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int t3_exp [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
  int t5_exp5 [4] = '{7, 10, 7, 8};
  int t5_sat4 [4] = '{0, 3, 3, 3};
  int t6_exp [3] = '{0, 1, -1};

  always #5 aclk = ~aclk;

  mash_dsm_nch #(.NUM_CH(2), .WIDTH(16), .FRAC_BW(12), .DAC_BW(5), .LFSR_SEED(16'hACE1)) dut (
    .aclk(aclk), .arst_n(arst_n), .mode(mode), .dither_enable(dither_enable),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(s_tready5),
    .m_axis_data_tdata(m_tdata5), .m_axis_data_tvalid(m_tvalid5), .m_axis_data_tready(m_tready),
    .sat_flag(sat5), .sat_clear(sat_clear)
  );

  mash_dsm_nch #(.NUM_CH(2), .WIDTH(16), .FRAC_BW(12), .DAC_BW(4), .LFSR_SEED(16'hACE1)) dut4 (
    .aclk(aclk), .arst_n(arst_n), .mode(mode), .dither_enable(dither_enable),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(s_tready4),
    .m_axis_data_tdata(m_tdata4), .m_axis_data_tvalid(m_tvalid4), .m_axis_data_tready(m_tready),
    .sat_flag(sat4), .sat_clear(sat_clear)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] code5(input int ch);
    logic signed [4:0] v;
    v = m_tdata5[ch*5 +: 5];
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] code4(input int ch);
    logic signed [3:0] v;
    v = m_tdata4[ch*4 +: 4];
    return 32'(v);
  endfunction

  // Present one beat on both channels and let it be accepted on the next rising edge.
  task automatic beat(input logic [1:0] m, input logic d, input logic [15:0] x, input logic clr);
    @(negedge aclk);
    mode          = m;
    dither_enable = d;
    s_tdata       = {x, x};
    s_tvalid      = 1'b1;
    m_tready      = 1'b1;
    sat_clear     = clr;
    #1;
    check("beat.s_tready", {s_tready5, s_tready4}, 2'b11);
    @(posedge aclk);
    #1;
    s_tvalid  = 1'b0;
    sat_clear = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input int e5, input int e4);
    check($sformatf("%s.vld", tag), {m_tvalid5, m_tvalid4}, 2'b11);
    for (int ch = 0; ch < 2; ch++) begin
      check($sformatf("%s.dac5.ch%0d", tag, ch), code5(ch), e5);
      check($sformatf("%s.dac4.ch%0d", tag, ch), code4(ch), e4);
    end
    $display("beat %s: dac5 ch0=%0d ch1=%0d dac4 ch0=%0d ch1=%0d sat5=%b sat4=%b",
             tag, code5(0), code5(1), code4(0), code4(1), sat5, sat4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sum;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst.vld", {m_tvalid5, m_tvalid4}, 2'b00);
    check("rst.data5", m_tdata5, 0);
    check("rst.data4", m_tdata4, 0);
    check("rst.sat", {sat5, sat4}, 0);
    check("rst.s_tready", {s_tready5, s_tready4}, 2'b11);
    @(negedge aclk);
    arst_n = 1'b1;

    // 1: bypass
    beat(2'b00, 1'b0, 16'hF000, 1'b0);
    expect_beat("t1.b0", 7, 7);
    beat(2'b00, 1'b0, 16'h0000, 1'b0);
    expect_beat("t1.b1", -8, -8);
    check("t1.sat", {sat5, sat4}, 0);

    // 2: MASH-1 with half-LSB fraction
    for (int i = 0; i < 8; i++) begin
      beat(2'b01, 1'b0, 16'h8800, 1'b0);
      expect_beat($sformatf("t2.b%0d", i), t2_exp[i], t2_exp[i]);
    end

    // 3: MASH 1-1 with quarter-LSB fraction
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      beat(2'b10, 1'b0, 16'h8400, 1'b0);
      expect_beat($sformatf("t3.b%0d", i), t3_exp[i % 8], t3_exp[i % 8]);
      sum += int'(code5(0));
    end
    check("t3.sum", sum, 4);

    // 4: backpressure after the first beat of a fresh MASH 1-1 run
    beat(2'b00, 1'b0, 16'h8400, 1'b0);
    expect_beat("t4.byp", 0, 0);
    beat(2'b10, 1'b0, 16'h8400, 1'b0);
    expect_beat("t4.b0", t3_exp[0], t3_exp[0]);
    @(negedge aclk);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = {16'hF000, 16'hF000};
    mode     = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(posedge aclk);
      #1;
      check($sformatf("t4.stall%0d.s_tready", k), {s_tready5, s_tready4}, 2'b00);
      check($sformatf("t4.stall%0d.vld", k), {m_tvalid5, m_tvalid4}, 2'b11);
      check($sformatf("t4.stall%0d.data5", k), m_tdata5, 0);
    end
    for (int i = 1; i < 8; i++) begin
      beat(2'b10, 1'b0, 16'h8400, 1'b0);
      expect_beat($sformatf("t4.b%0d", i), t3_exp[i], t3_exp[i]);
    end

    // 5: MASH 1-1-1 at full scale; DAC_BW=4 instance saturates
    for (int i = 0; i < 4; i++) begin
      beat(2'b11, 1'b0, 16'hFFFF, 1'b0);
      expect_beat($sformatf("t5.b%0d", i), t5_exp5[i], 7);
      check($sformatf("t5.b%0d.sat4", i), sat4, t5_sat4[i]);
      check($sformatf("t5.b%0d.sat5", i), sat5, 0);
    end
    beat(2'b11, 1'b0, 16'h8000, 1'b1);
    expect_beat("t5.clr", 0, 0);
    check("t5.clr.sat4", sat4, 0);

    // 6: mode switch 10 -> 11 mid-stream, then reset during a stall
    for (int i = 0; i < 3; i++) begin
      beat(2'b10, 1'b0, 16'h8400, 1'b0);
      expect_beat($sformatf("t6.m10.b%0d", i), t3_exp[i], t3_exp[i]);
    end
    for (int i = 0; i < 3; i++) begin
      beat(2'b11, 1'b0, 16'h8400, 1'b0);
      expect_beat($sformatf("t6.m11.b%0d", i), t6_exp[i], t6_exp[i]);
    end
    @(negedge aclk);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    check("t6.stall.s_tready", {s_tready5, s_tready4}, 2'b00);
    check("t6.stall.held", code5(0), -1);
    #2;
    arst_n = 1'b0;
    #1;
    check("t6.rst.vld", {m_tvalid5, m_tvalid4}, 2'b00);
    check("t6.rst.data5", m_tdata5, 0);
    check("t6.rst.data4", m_tdata4, 0);
    @(negedge aclk);
    arst_n   = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    check("t6.idle.vld", {m_tvalid5, m_tvalid4}, 2'b00);
    // LFSR seed 0xACE1 gives dither 1 then 0 on the first two beats
    beat(2'b01, 1'b1, 16'h8FFF, 1'b0);
    expect_beat("t6.lfsr.b0", 1, 1);
    beat(2'b01, 1'b1, 16'h8FFF, 1'b0);
    expect_beat("t6.lfsr.b1", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
